// File: rtl/stu_pkg.sv
// Shared constants for the multi-channel sensor status checker:
// status bit positions within a channel nibble and the window FSM encoding.
package stu_pkg;
  localparam int STU_TO    = 0;
  localparam int STU_STUCK = 1;
  localparam int STU_HI    = 2;
  localparam int STU_LO    = 3;
  localparam int STU_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } stu_state_e;
endpackage

// File: rtl/stu_check_mc_if.sv
// ADC sample bus feeding the status checker: one valid-qualified sample per
// clock, tagged with its channel index.
interface stu_check_mc_if #(
  parameter int DW  = 16,
  parameter int CHW = 2
);
  logic           ad_vld;
  logic [DW-1:0]  ad_data;
  logic [CHW-1:0] ad_ch;

  modport master (output ad_vld, ad_data, ad_ch);
  modport slave  (input  ad_vld, ad_data, ad_ch);
endinterface

// File: rtl/stu_chan.sv
// One channel of the checker: last-sample/run tracking for stuck detection,
// range compares, seen flag for the timeout, and four sticky status bits.
module stu_chan
  import stu_pkg::*;
#(
  parameter int DW        = 16,
  parameter int STUCK_CNT = 64
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             smp,
  input  logic [DW-1:0]    data,
  input  logic [DW-1:0]    cfg_hi,
  input  logic [DW-1:0]    cfg_lo,
  input  logic             arm,
  input  logic             clr,
  input  logic             to_fire,
  output logic [STU_W-1:0] stat
);
  localparam int             RW      = $clog2(STUCK_CNT);
  localparam logic [RW-1:0]  RUN_MAX = RW'(STUCK_CNT - 1);

  logic [DW-1:0]    last;
  logic [RW-1:0]    run, run_nxt;
  logic             got_first, seen, same;
  logic [STU_W-1:0] stat_nxt;

  assign same = got_first && (data == last);

  // run counts repeats after the first of a sequence and saturates at RUN_MAX
  always_comb begin
    run_nxt = run;
    if (smp) begin
      if (!same)                run_nxt = '0;
      else if (run != RUN_MAX)  run_nxt = run + 1'b1;
    end
  end

  // clear first so that a coincident set event wins over clr
  always_comb begin
    stat_nxt = clr ? '0 : stat;
    if (to_fire && !seen) stat_nxt[STU_TO] = 1'b1;
    if (smp) begin
      if (data > cfg_hi)                stat_nxt[STU_HI]    = 1'b1;
      if (data < cfg_lo)                stat_nxt[STU_LO]    = 1'b1;
      if (same && run_nxt == RUN_MAX)   stat_nxt[STU_STUCK] = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      stat      <= '0;
      last      <= '0;
      run       <= '0;
      got_first <= 1'b0;
      seen      <= 1'b0;
    end else if (arm) begin
      stat      <= '0;
      run       <= '0;
      got_first <= 1'b0;
      seen      <= 1'b0;
    end else begin
      stat <= stat_nxt;
      run  <= run_nxt;
      if (smp) begin
        seen      <= 1'b1;
        got_first <= 1'b1;
        last      <= data;
      end
    end
  end
endmodule

// File: rtl/stu_check_mc.sv
// Multi-channel sensor status checker: arms a check window on each ast rising
// edge and reports per-channel timeout, stuck, over- and under-range faults.
module stu_check_mc
  import stu_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int DW        = 16,
  parameter int CHW       = 2,
  parameter int STUCK_CNT = 64,
  parameter int TO_US     = 1000,
  parameter int TOW       = 16
) (
  input  logic                   clk_sys,
  input  logic                   rst,
  input  logic                   pluse_us,
  input  logic                   ast,
  input  logic [DW-1:0]          cfg_hi,
  input  logic [DW-1:0]          cfg_lo,
  input  logic                   clr,
  stu_check_mc_if.slave          ad,
  output logic [STU_W*NCH-1:0]   stu_sensor,
  output logic                   stu_any
);
  stu_state_e               state_q, state_d;
  logic                     ast_d, arm, to_term, to_fire, acc;
  logic [TOW-1:0]           to_cnt;
  logic [NCH-1:0][STU_W-1:0] stat;

  assign arm     = ast & ~ast_d;
  assign to_term = pluse_us && (to_cnt == TOW'(TO_US - 1));
  assign to_fire = (state_q == ST_RUN) && to_term && !arm;
  // out-of-range channel indices are dropped here, before decode
  assign acc     = ad.ad_vld && (state_q != ST_IDLE) && !arm && (int'(ad.ad_ch) < NCH);

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      ast_d   <= 1'b0;
      state_q <= ST_IDLE;
      to_cnt  <= '0;
      stu_any <= 1'b0;
    end else begin
      ast_d   <= ast;
      state_q <= state_d;
      stu_any <= |stu_sensor;
      if (arm)                                to_cnt <= '0;
      else if (state_q == ST_RUN && pluse_us) to_cnt <= to_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_RUN:  if (to_term) state_d = ST_DONE;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    if (arm) state_d = ST_RUN;
  end

  for (genvar n = 0; n < NCH; n++) begin : g_chan
    stu_chan #(.DW(DW), .STUCK_CNT(STUCK_CNT)) u_chan (
      .clk_sys (clk_sys),
      .rst     (rst),
      .smp     (acc && (ad.ad_ch == CHW'(n))),
      .data    (ad.ad_data),
      .cfg_hi  (cfg_hi),
      .cfg_lo  (cfg_lo),
      .arm     (arm),
      .clr     (clr),
      .to_fire (to_fire),
      .stat    (stat[n])
    );
  end

  assign stu_sensor = stat;
endmodule

// File: tb/tb_stu_check_mc.sv
// Bench for stu_check_mc: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a behavioural model.
module tb_stu_check_mc;
  localparam int NCH = 4, DW = 16, CHW = 3, STUCK_CNT = 64, TO_US = 1000, TOW = 16;

  logic              clk_sys = 1'b0;
  logic              rst, pluse_us, ast, clr;
  logic [DW-1:0]     cfg_hi, cfg_lo;
  logic [4*NCH-1:0]  stu_sensor;
  logic              stu_any;

  stu_check_mc_if #(.DW(DW), .CHW(CHW)) ad_if ();

  stu_check_mc #(.NCH(NCH), .DW(DW), .CHW(CHW), .STUCK_CNT(STUCK_CNT),
                 .TO_US(TO_US), .TOW(TOW)) dut (
    .clk_sys(clk_sys), .rst(rst), .pluse_us(pluse_us), .ast(ast),
    .cfg_hi(cfg_hi), .cfg_lo(cfg_lo), .clr(clr), .ad(ad_if),
    .stu_sensor(stu_sensor), .stu_any(stu_any));

  always #5 clk_sys = ~clk_sys;

  int nvec = 0, nerr = 0;

  // behavioural model: window armed/expired flags, tick count, per-channel run length
  bit [3:0]      m_stat [NCH];
  bit            m_seen [NCH];
  bit            m_have [NCH];
  logic [DW-1:0] m_last [NCH];
  int            m_cnt  [NCH];
  bit            m_active = 0, m_expired = 0, m_ast_prev = 0, m_any = 0;
  int            m_ticks = 0;

  function automatic logic [4*NCH-1:0] exp_sensor();
    logic [4*NCH-1:0] r;
    for (int n = 0; n < NCH; n++) r[4*n +: 4] = m_stat[n];
    return r;
  endfunction

  always @(posedge clk_sys or posedge rst) begin : model
    bit            arm;
    int            c;
    logic [DW-1:0] d;
    if (rst) begin
      m_ast_prev = 0; m_active = 0; m_expired = 0; m_ticks = 0; m_any = 0;
      for (int k = 0; k < NCH; k++) begin
        m_stat[k] = 0; m_seen[k] = 0; m_have[k] = 0; m_cnt[k] = 0; m_last[k] = 0;
      end
    end else begin
      m_any = (exp_sensor() != 0);
      arm = ast && !m_ast_prev;
      m_ast_prev = ast;
      if (arm) begin
        m_active = 1; m_expired = 0; m_ticks = 0;
        for (int k = 0; k < NCH; k++) begin
          m_stat[k] = 0; m_seen[k] = 0; m_have[k] = 0; m_cnt[k] = 0;
        end
      end else begin
        if (clr) for (int k = 0; k < NCH; k++) m_stat[k] = 0;
        if (m_active && !m_expired && pluse_us) begin
          m_ticks++;
          if (m_ticks == TO_US) begin
            m_expired = 1;
            for (int k = 0; k < NCH; k++) if (!m_seen[k]) m_stat[k][0] = 1;
          end
        end
        if (m_active && ad_if.ad_vld && ad_if.ad_ch < NCH) begin
          c = int'(ad_if.ad_ch);
          d = ad_if.ad_data;
          m_seen[c] = 1;
          if (d > cfg_hi) m_stat[c][2] = 1;
          if (d < cfg_lo) m_stat[c][3] = 1;
          if (m_have[c] && d == m_last[c]) m_cnt[c]++;
          else begin m_have[c] = 1; m_last[c] = d; m_cnt[c] = 1; end
          if (m_cnt[c] >= STUCK_CNT) m_stat[c][1] = 1;
        end
      end
    end
  end

  always @(negedge clk_sys) begin
    nvec++;
    if (stu_sensor !== exp_sensor() || stu_any !== m_any) begin
      nerr++;
      $display("FAIL model t=%0t: stu_sensor=%h stu_any=%b, required %h %b",
               $time, stu_sensor, stu_any, exp_sensor(), m_any);
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic step(bit v, int ch, logic [DW-1:0] d, bit tk);
    ad_if.ad_vld  = v;
    ad_if.ad_ch   = CHW'(ch);
    ad_if.ad_data = d;
    pluse_us      = tk;
    @(negedge clk_sys);
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 0, '0, 0);
  endtask

  task automatic tick_n(int n);
    repeat (n) begin step(0, 0, '0, 1); step(0, 0, '0, 0); end
  endtask

  task automatic arm_win();
    ast = 0; idle(1);
    ast = 1; idle(1);
  endtask

  logic [DW-1:0] rep [8];
  bit            prev_tk;

  initial begin
    rst = 1; ast = 0; clr = 0; pluse_us = 0;
    ad_if.ad_vld = 0; ad_if.ad_ch = '0; ad_if.ad_data = '0;
    cfg_hi = 16'hF000; cfg_lo = 16'h0100;
    idle(2);
    chk("reset_sensor", 32'(stu_sensor), 0);
    chk("reset_any", 32'(stu_any), 0);

    // ast held high through reset arms on the first cycle after release
    ast = 1; idle(1);
    rst = 0; idle(1);
    for (int c = 0; c < NCH; c++) step(1, c, 16'h1000, 0);
    tick_n(TO_US);
    chk("all_seen_sensor", 32'(stu_sensor), 0);
    chk("all_seen_any", 32'(stu_any), 0);

    arm_win();
    for (int c = 0; c < 3; c++) step(1, c, 16'h1000, 0);
    tick_n(TO_US - 1);
    chk("to_before_last_tick", 32'(stu_sensor), 0);
    step(0, 0, '0, 1);
    chk("to_ch3", 32'(stu_sensor), 32'h1000);
    chk("to_any_lag", 32'(stu_any), 0);
    idle(1);
    chk("to_any", 32'(stu_any), 1);

    arm_win();
    repeat (STUCK_CNT - 1) step(1, 1, 16'h2222, 0);
    chk("stuck_63", 32'(stu_sensor[5]), 0);
    step(1, 1, 16'h2222, 0);
    chk("stuck_64", 32'(stu_sensor[5]), 1);
    arm_win();
    repeat (STUCK_CNT - 1) step(1, 1, 16'h2222, 0);
    step(1, 1, 16'h2223, 0);
    chk("stuck_broken", 32'(stu_sensor[5]), 0);

    arm_win();
    step(1, 2, 16'hF001, 0);
    chk("over_range", 32'(stu_sensor[10]), 1);
    step(1, 2, 16'h00FF, 0);
    chk("under_range", 32'(stu_sensor[11]), 1);
    arm_win();
    step(1, 2, 16'hF000, 0);
    step(1, 2, 16'h0100, 0);
    chk("at_limits", 32'(stu_sensor), 0);

    step(1, 0, 16'hFFFF, 0);
    chk("pre_arm_fault", 32'(stu_sensor[2]), 1);
    ast = 0; idle(1);
    ast = 1; step(1, 0, 16'hFFFF, 0);
    chk("arm_beats_vld", 32'(stu_sensor), 0);
    step(1, 1, 16'hFFFF, 0);
    chk("ch1_over", 32'(stu_sensor), 32'h0040);
    clr = 1; idle(1); clr = 0;
    chk("clr", 32'(stu_sensor), 0);
    tick_n(TO_US);
    chk("clr_keeps_seen", 32'(stu_sensor), 32'h1101);

    arm_win();
    tick_n(TO_US - 1);
    ast = 0; idle(1);
    ast = 1; step(0, 0, '0, 1);
    chk("arm_beats_tick", 32'(stu_sensor), 0);

    arm_win();
    step(1, 5, 16'hFFFF, 0);
    chk("ch5_ignored", 32'(stu_sensor), 0);
    tick_n(TO_US);
    chk("ch5_not_seen", 32'(stu_sensor), 32'h1111);

    arm_win();
    step(1, 3, 16'hFFFF, 0);
    idle(2);
    #2 rst = 1;
    #1;
    chk("async_rst_sensor", 32'(stu_sensor), 0);
    chk("async_rst_any", 32'(stu_any), 0);
    @(negedge clk_sys);
    ast = 0; rst = 0;
    idle(2);

    arm_win();
    for (int i = 0; i < 8; i++) rep[i] = 16'($urandom);
    prev_tk = 0;
    repeat (9000) begin
      bit v, tk;
      int ch;
      if ($urandom_range(0, 1999) == 0) ast = ~ast;
      clr = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 499) == 0) begin
        cfg_lo = 16'($urandom_range(0, 16'h4000));
        cfg_hi = 16'($urandom_range(16'h3000, 16'hFFFF));
      end
      v  = ($urandom_range(0, 1) == 1);
      ch = $urandom_range(0, 7);
      if (v && $urandom_range(0, 63) == 0) rep[ch] = 16'($urandom);
      tk = !prev_tk && ($urandom_range(0, 2) == 0);
      prev_tk = tk;
      step(v, ch, rep[ch], tk);
    end
    clr = 0;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/stu_check_mc.md
Name: stu_check_mc

Overview:
Parametrised multi-channel sensor status checker; successor to the fixed 8-bit, no-logic sensor status stub. Monitors the ADC sample stream after each acquisition start (ast). Per channel it flags four faults: no data (timeout), stuck value, over-range and under-range. Sits in ast_top between the ADC capture path and the configuration/status register bank, which reads stu_sensor.

Parameters:
NCH, 4, number of ADC channels monitored (1..16)
DW, 16, ADC sample width
CHW, 2, channel index width; must satisfy 2**CHW >= NCH
STUCK_CNT, 64, consecutive identical samples that declare a channel stuck (>=2)
TO_US, 1000, microseconds after ast within which every channel must deliver a sample
TOW, 16, timeout counter width; must satisfy 2**TOW > TO_US

Ports:
clk_sys  in  1  system clock
rst  in  1  asynchronous active-high reset
pluse_us  in  1  one-clk_sys-wide tick, once per microsecond
ast  in  1  acquisition start, level; rising edge arms a new check window
ad_data  in  DW  ADC sample
ad_vld  in  1  ad_data/ad_ch valid strobe, one cycle per sample
ad_ch  in  CHW  channel index of the current sample
cfg_hi  in  DW  upper limit, unsigned
cfg_lo  in  DW  lower limit, unsigned
clr  in  1  synchronous pulse; clears all status bits, state unchanged
stu_sensor  out  4*NCH  per-channel status; channel n occupies bits [4n+3:4n]: bit0 timeout, bit1 stuck, bit2 over-range, bit3 under-range
stu_any  out  1  OR of all stu_sensor bits, registered

Behaviour:
- Reset: stu_sensor=0, stu_any=0, state IDLE, all counters, seen flags and last-sample registers 0.
- ast edge detect: ast_d registered; arm = ast & ~ast_d. Reset leaves ast_d=0, so ast held high through reset arms on the first cycle after release.
- FSM states: IDLE, RUN, DONE.
  - IDLE: samples ignored, status held. On arm -> RUN.
  - RUN: timeout counter counts pluse_us ticks. On the tick where count == TO_US-1, set the timeout bit of every channel whose seen flag is 0 -> DONE.
  - DONE: stuck and range checks continue, timeout counter frozen. On arm -> RUN.
  - Arm in RUN or DONE restarts the window: -> RUN.
- Arm in any state, same cycle:
  - clears stu_sensor, seen flags, stuck counters, first-sample flags and the timeout counter;
  - has priority over a coincident ad_vld, whose sample is discarded;
  - has priority over a coincident terminal pluse_us tick, so no timeout is set.
- Sample acceptance: ad_vld=1, state RUN or DONE, ad_ch < NCH, no arm. ad_ch >= NCH is silently dropped.
- Per accepted sample on channel c:
  - seen[c] <= 1.
  - Range: ad_data > cfg_hi sets over-range; ad_data < cfg_lo sets under-range. Compares are unsigned; equality is in range. If cfg_lo > cfg_hi, both bits may set on a single sample; no protection is provided.
  - Stuck: the first sample after arm only loads last[c]. Each later sample equal to last[c] increments run[c], saturating. A differing sample resets run[c] to 0 and loads last[c]. When run[c] reaches STUCK_CNT-1 (STUCK_CNT identical samples in total), set stuck.
- All status bits are sticky until arm, clr or rst. clr clears status bits only; seen flags, counters and state are kept. If clr coincides with a set event, the set wins.
- Latency: a status bit is visible on stu_sensor 1 clk after the ad_vld or pluse_us that caused it; stu_any follows 1 clk later.
- Throughput: one sample per clock; back-to-back ad_vld on the same channel must be handled.

Decomposition:
- Package stu_pkg: status bit index constants STU_TO=0, STU_STUCK=1, STU_HI=2, STU_LO=3, STU_W=4; FSM state encoding.
- Sub-module stu_chan: one channel's last-sample register, saturating run counter, first and seen flags, and 4 sticky bits. Inputs: sample strobe, data, limits, arm, clr, timeout-fire. Instantiated NCH times via generate.
- The top holds the ast edge detect, FSM, timeout counter and channel decode.

Test Plan:
- Reset, ast rises, each of the 4 channels sends 0x1000 once, cfg_hi=0xF000, cfg_lo=0x0100, wait 1000 us -> stu_sensor=0x0000, state DONE, stu_any=0.
- ast rises, only ch0..2 sample, 1000 pluse_us ticks -> stu_sensor=0x1000 (ch3 timeout) 1 clk after the 1000th tick; stu_any=1 one clk later.
- Ch1 sends 0x2222 64 times back-to-back -> ch1 stuck bit sets 1 clk after the 64th sample (stu_sensor[5]=1); 63 identical then 0x2223 -> no stuck bit.
- Ch2 sample 0xF001 with cfg_hi=0xF000 -> stu_sensor[10]=1; sample 0x00FF with cfg_lo=0x0100 -> stu_sensor[11]=1; samples equal to each limit -> no bit.
- Faults latched, then ast rises in the same cycle as an ad_vld of 0xFFFF on ch0 -> stu_sensor=0 and no over-range bit. clr pulse mid-RUN -> status cleared, timeout still fires at 1000 us.
- ad_vld with ad_ch=5 (NCH=4, CHW=3 build) -> ignored, no seen update. rst asserted mid-RUN -> all outputs 0 asynchronously, FSM IDLE.
